// File: rtl/axil_reg_pkg.sv
// Shared constants and state types for the AXI4-Lite register slave.
package axil_reg_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [11:0] RO_BASE     = 12'h100;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ACC  = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACC  = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  // Register index width covering both banks, never narrower than one bit.
  function automatic int idx_width(input int n_rw, input int n_ro);
    int m;
    m = (n_rw > n_ro) ? n_rw : n_ro;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// Byte-offset decoder: classifies an offset as control (RW) or status (RO) and yields the word index.
module axil_addr_decode
  import axil_reg_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int NUM_RW = 8,
  parameter int NUM_RO = 8,
  parameter int IDX_W  = idx_width(NUM_RW, NUM_RO)
) (
  input  logic [ADDR_W-1:0] offset,
  output logic              rw_hit,
  output logic              ro_hit,
  output logic [IDX_W-1:0]  index
);

  localparam logic [ADDR_W:0] RW_END = (ADDR_W+1)'(4 * NUM_RW);
  localparam logic [ADDR_W:0] RO_LO  = (ADDR_W+1)'(RO_BASE);
  localparam logic [ADDR_W:0] RO_HI  = (ADDR_W+1)'(int'(RO_BASE) + 4 * NUM_RO);

  logic [ADDR_W:0] off_ext_s;

  // Range compare; RO_BASE is aligned well beyond the bank size, so the low word bits are the index in both banks.
  always_comb begin
    off_ext_s = {1'b0, offset};
    rw_hit    = (off_ext_s < RW_END);
    ro_hit    = (off_ext_s >= RO_LO) && (off_ext_s < RO_HI);
    if (rw_hit || ro_hit) begin
      index = offset[2 +: IDX_W];
    end else begin
      index = '0;
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_RW control registers and NUM_RO status registers,
// with independent single-outstanding write and read channels.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int          ADDR_W = 12,
  parameter int          NUM_RW = 8,
  parameter int          NUM_RO = 8,
  parameter logic [31:0] RW_RST = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_axil_awvalid,
  input  logic [31:0]          s_axil_awaddr,
  output logic                 s_axil_awready,
  input  logic                 s_axil_wvalid,
  input  logic [31:0]          s_axil_wdata,
  output logic                 s_axil_wready,
  output logic                 s_axil_bvalid,
  output logic [1:0]           s_axil_bresp,
  input  logic                 s_axil_bready,
  input  logic                 s_axil_arvalid,
  input  logic [31:0]          s_axil_araddr,
  output logic                 s_axil_arready,
  output logic                 s_axil_rvalid,
  output logic [31:0]          s_axil_rdata,
  output logic [1:0]           s_axil_rresp,
  input  logic                 s_axil_rready,
  output logic [32*NUM_RW-1:0] ctrl_regs,
  output logic [NUM_RW-1:0]    ctrl_wr_pulse,
  input  logic [32*NUM_RO-1:0] status_regs
);

  localparam int IDX_W = idx_width(NUM_RW, NUM_RO);

  wr_state_t wr_state_r, wr_state_s;
  rd_state_t rd_state_r, rd_state_s;

  logic [31:0]       ctrl_r [NUM_RW];
  logic [NUM_RW-1:0] wr_pulse_r;
  logic [1:0]        bresp_r;
  logic [1:0]        rresp_r;
  logic [31:0]       rdata_r;
  logic [31:0]       rd_word_s;

  logic              aw_ready_s, w_ready_s, b_valid_s;
  logic              ar_ready_s, r_valid_s;

  logic              aw_rw_hit_s, aw_ro_hit_s, ar_rw_hit_s, ar_ro_hit_s;
  logic [IDX_W-1:0]  aw_idx_s, ar_idx_s;
  logic              unused_s;

  axil_addr_decode #(.ADDR_W(ADDR_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .IDX_W(IDX_W)) u_aw_decode (
    .offset (s_axil_awaddr[ADDR_W-1:0]),
    .rw_hit (aw_rw_hit_s),
    .ro_hit (aw_ro_hit_s),
    .index  (aw_idx_s)
  );

  axil_addr_decode #(.ADDR_W(ADDR_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .IDX_W(IDX_W)) u_ar_decode (
    .offset (s_axil_araddr[ADDR_W-1:0]),
    .rw_hit (ar_rw_hit_s),
    .ro_hit (ar_ro_hit_s),
    .index  (ar_idx_s)
  );

  // Upper address bits are outside the decoded window; writes only need the RW hit.
  assign unused_s = ^{s_axil_awaddr[31:ADDR_W], s_axil_araddr[31:ADDR_W], aw_ro_hit_s};

  // State registers for both channel FSMs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r <= W_IDLE;
      rd_state_r <= R_IDLE;
    end else begin
      wr_state_r <= wr_state_s;
      rd_state_r <= rd_state_s;
    end
  end

  // Write next state: accept only when address and data arrive together.
  always_comb begin
    wr_state_s = wr_state_r;
    case (wr_state_r)
      W_IDLE: begin
        if (s_axil_awvalid && s_axil_wvalid) wr_state_s = W_ACC;
        else                                 wr_state_s = W_IDLE;
      end
      W_ACC:  wr_state_s = W_RESP;
      W_RESP: begin
        if (s_axil_bready) wr_state_s = W_IDLE;
        else               wr_state_s = W_RESP;
      end
      default: wr_state_s = W_IDLE;
    endcase
  end

  // Read next state.
  always_comb begin
    rd_state_s = rd_state_r;
    case (rd_state_r)
      R_IDLE: begin
        if (s_axil_arvalid) rd_state_s = R_ACC;
        else                rd_state_s = R_IDLE;
      end
      R_ACC:  rd_state_s = R_DATA;
      R_DATA: begin
        if (s_axil_rready) rd_state_s = R_IDLE;
        else               rd_state_s = R_DATA;
      end
      default: rd_state_s = R_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state flops; ready exists only in the accept states.
  always_comb begin
    aw_ready_s = (wr_state_r == W_ACC);
    w_ready_s  = (wr_state_r == W_ACC);
    b_valid_s  = (wr_state_r == W_RESP);
    ar_ready_s = (rd_state_r == R_ACC);
    r_valid_s  = (rd_state_r == R_DATA);
  end

  // Write commit, one-cycle pulse and response code.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RW; i++) ctrl_r[i] <= RW_RST;
      wr_pulse_r <= '0;
      bresp_r    <= RESP_OKAY;
    end else begin
      wr_pulse_r <= '0;
      if (wr_state_r == W_ACC) begin
        bresp_r <= aw_rw_hit_s ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_RW; i++) begin
          if (aw_rw_hit_s && (aw_idx_s == IDX_W'(i))) begin
            ctrl_r[i]     <= s_axil_wdata;
            wr_pulse_r[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Read mux; uses pre-commit register contents, so a same-edge write is not visible.
  always_comb begin
    rd_word_s = 32'h0;
    for (int i = 0; i < NUM_RW; i++) begin
      rd_word_s = rd_word_s | ((ar_rw_hit_s && (ar_idx_s == IDX_W'(i))) ? ctrl_r[i] : 32'h0);
    end
    for (int i = 0; i < NUM_RO; i++) begin
      rd_word_s = rd_word_s | ((ar_ro_hit_s && (ar_idx_s == IDX_W'(i))) ? status_regs[32*i +: 32] : 32'h0);
    end
  end

  // Read data capture at the accept edge, held through the data phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= 32'h0;
      rresp_r <= RESP_OKAY;
    end else if (rd_state_r == R_ACC) begin
      rdata_r <= rd_word_s;
      rresp_r <= (ar_rw_hit_s || ar_ro_hit_s) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl_flat
    assign ctrl_regs[32*g +: 32] = ctrl_r[g];
  end

  assign s_axil_awready = aw_ready_s;
  assign s_axil_wready  = w_ready_s;
  assign s_axil_bvalid  = b_valid_s;
  assign s_axil_bresp   = bresp_r;
  assign s_axil_arready = ar_ready_s;
  assign s_axil_rvalid  = r_valid_s;
  assign s_axil_rdata   = rdata_r;
  assign s_axil_rresp   = rresp_r;
  assign ctrl_wr_pulse  = wr_pulse_r;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave with response scoreboards for the B and R channels.
module tb_axil_reg_slave;
  import axil_reg_pkg::*;

  localparam int NUM_RW = 8;
  localparam int NUM_RO = 8;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]          awaddr = 32'h0, wdata = 32'h0, araddr = 32'h0;
  logic                 awready, wready, bvalid, arready, rvalid;
  logic [1:0]           bresp, rresp;
  logic [31:0]          rdata;
  logic [32*NUM_RW-1:0] ctrl_regs;
  logic [NUM_RW-1:0]    ctrl_wr_pulse;
  logic [32*NUM_RO-1:0] status_regs;

  logic [31:0] model    [NUM_RW];
  logic [31:0] status_m [NUM_RO];
  logic [1:0]  exp_b_q  [$];
  rexp_t       exp_r_q  [$];

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  axil_reg_slave dut (
    .clk(clk), .rst(rst),
    .s_axil_awvalid(awvalid), .s_axil_awaddr(awaddr), .s_axil_awready(awready),
    .s_axil_wvalid(wvalid), .s_axil_wdata(wdata), .s_axil_wready(wready),
    .s_axil_bvalid(bvalid), .s_axil_bresp(bresp), .s_axil_bready(bready),
    .s_axil_arvalid(arvalid), .s_axil_araddr(araddr), .s_axil_arready(arready),
    .s_axil_rvalid(rvalid), .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rready(rready),
    .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse), .status_regs(status_regs)
  );

  always_comb begin
    for (int i = 0; i < NUM_RO; i++) status_regs[32*i +: 32] = status_m[i];
  end

  always @(negedge clk) pulse_cnt <= pulse_cnt + $countones(ctrl_wr_pulse);

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < NUM_RW; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int bdelay);
    logic [11:0]       off;
    logic [2:0]        w;
    logic [NUM_RW-1:0] exp_pulse;
    int                n;
    off = addr[11:0];
    w   = off[4:2];
    exp_pulse = '0;
    if (off < 12'h020) begin
      exp_b_q.push_back(RESP_OKAY);
      exp_pulse[w] = 1'b1;
    end else begin
      exp_b_q.push_back(RESP_SLVERR);
    end
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!awready && n < 20);
    chk("aw_ready_latency", n, 1);
    chk("w_ready", wready, 1'b1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("b_valid_latency", bvalid, 1'b1);
    chk("aw_ready_once", awready, 1'b0);
    chk("wr_pulse", ctrl_wr_pulse, exp_pulse);
    if (off < 12'h020) model[int'(w)] = data;
    chk("ctrl_regs", ctrl_regs, model_flat());
    for (int i = 0; i < bdelay; i++) begin
      tick();
      chk("b_hold_valid", bvalid, 1'b1);
      chk("b_hold_resp", bresp, exp_b_q[0]);
    end
    bready = 1'b1;
    chk("bresp", bresp, exp_b_q.pop_front());
    tick();
    bready = 1'b0;
    chk("b_done", bvalid, 1'b0);
    chk("wr_pulse_clear", ctrl_wr_pulse, '0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdelay);
    logic [11:0] off;
    logic [2:0]  w;
    rexp_t       e;
    int          n;
    off = addr[11:0];
    w   = off[4:2];
    if (off < 12'h020) begin
      e.data = model[int'(w)]; e.resp = RESP_OKAY;
    end else if (off >= 12'h100 && off < 12'h120) begin
      e.data = status_m[int'(w)]; e.resp = RESP_OKAY;
    end else begin
      e.data = 32'h0; e.resp = RESP_SLVERR;
    end
    exp_r_q.push_back(e);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!arready && n < 20);
    chk("ar_ready_latency", n, 1);
    tick();
    arvalid = 1'b0;
    chk("r_valid_latency", rvalid, 1'b1);
    chk("ar_ready_once", arready, 1'b0);
    for (int i = 0; i < rdelay; i++) begin
      tick();
      chk("r_hold_valid", rvalid, 1'b1);
      chk("r_hold_data", rdata, exp_r_q[0].data);
    end
    rready = 1'b1;
    e = exp_r_q.pop_front();
    chk("rdata", rdata, e.data);
    chk("rresp", rresp, e.resp);
    tick();
    rready = 1'b0;
    chk("r_done", rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    for (int i = 0; i < NUM_RW; i++) model[i] = 32'h0;
    for (int i = 0; i < NUM_RO; i++) status_m[i] = 32'h1000_0000 + 32'(i);

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_awready", awready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bresp_rresp", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ctrl", ctrl_regs, 256'h0);
    chk("rst_pulse", ctrl_wr_pulse, 8'h00);
    rst = 1'b0;
    tick();

    // Basic write and readback, status read
    do_write(32'h0000_0004, 32'hA5A5_0001, 0);
    do_read(32'h0000_0004, 0);
    status_m[3] = 32'hCAFE_F00D;
    tick();
    do_read(32'h0000_010C, 0);

    // Error paths: RO write, unmapped write/read, RO read
    do_write(32'h0000_0104, 32'hDEAD_0001, 0);
    do_write(32'h0000_0080, 32'hDEAD_0002, 0);
    do_read(32'h0000_0080, 0);
    do_read(32'h0000_0104, 0);

    // Back-pressure on R and B, upper address bits ignored
    do_read(32'h0000_0004, 10);
    do_write(32'hFFFF_F01C, 32'h7777_0007, 5);
    do_read(32'h0000_001C, 0);

    // Same-register read/write collision returns the pre-write value
    fork
      do_write(32'h0000_0004, 32'h1111_2222, 0);
      do_read(32'h0000_0004, 0);
    join
    do_read(32'h0000_0004, 0);

    // AW ahead of W; valids held past handshake must not re-accept
    p0 = pulse_cnt;
    awaddr = 32'h0000_000C; wdata = 32'h0000_5555; awvalid = 1'b1; wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("aw_wait_no_ready", awready, 1'b0);
    end
    wvalid = 1'b1;
    tick();
    chk("aw_ready_after_w", awready, 1'b1);
    tick();
    chk("early_aw_bvalid", bvalid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_double_accept", {awready, wready}, 2'b00);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    chk("early_aw_bresp", bresp, RESP_OKAY);
    tick();
    bready = 1'b0;
    chk("early_aw_bdone", bvalid, 1'b0);
    tick(); tick();
    model[3] = 32'h0000_5555;
    chk("single_pulse", pulse_cnt - p0, 1);
    chk("early_aw_ctrl", ctrl_regs, model_flat());

    // Reset during W_RESP and R_DATA
    awaddr = 32'h0000_0008; wdata = 32'hBAD0_0008; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h0000_0004; arvalid = 1'b1;
    tick(); tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("pre_rst_resp_pending", {bvalid, rvalid}, 2'b11);
    rst = 1'b1;
    tick();
    chk("mid_rst_valids", {bvalid, rvalid, awready, arready}, 4'b0000);
    chk("mid_rst_ctrl", ctrl_regs, 256'h0);
    rst = 1'b0;
    for (int i = 0; i < NUM_RW; i++) model[i] = 32'h0;
    tick();
    do_write(32'h0000_0008, 32'h600D_0006, 0);
    do_read(32'h0000_0008, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
